// File: rtl/reaction_sequencer.sv
// Round controller for the reaction timer: arms the LED sweep, waits a pseudo-random
// hold-off, lights GO, and times the react press with false-start and timeout detection.
module reaction_sequencer #(
  parameter int         CNT_W     = 8,
  parameter int         ARM_TICKS = 4,
  parameter int         MIN_DELAY = 5,
  parameter int         RAND_W    = 4,
  parameter int         TIMEOUT   = 50,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk5Hz,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_react,
  output logic             o_step_en,
  output logic             o_go_led,
  output logic             o_false_start,
  output logic             o_timeout,
  output logic             o_result_valid,
  output logic [CNT_W-1:0] o_result,
  output logic [CNT_W-1:0] o_best
);

  localparam int ARM_W = (ARM_TICKS > 1) ? $clog2(ARM_TICKS) : 1;
  localparam int DLY_W = $clog2(MIN_DELAY + (1 << RAND_W));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_GO    = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_start_q;
  logic               r_react_q;
  logic [7:0]         r_lfsr;
  logic [ARM_W-1:0]   r_arm_cnt;
  logic [DLY_W-1:0]   r_dly;
  logic [CNT_W-1:0]   r_rt;
  logic [CNT_W-1:0]   r_result;
  logic [CNT_W-1:0]   r_best;
  logic               r_timeout;

  state_t             w_state_next;
  logic [ARM_W-1:0]   w_arm_cnt_next;
  logic [DLY_W-1:0]   w_dly_next;
  logic [CNT_W-1:0]   w_rt_next;
  logic [CNT_W-1:0]   w_result_next;
  logic [CNT_W-1:0]   w_best_next;
  logic               w_timeout_next;

  logic               w_start_rise;
  logic               w_react_rise;
  logic               w_lfsr_fb;
  logic [DLY_W-1:0]   w_dly_load;

  assign w_start_rise = i_start & ~r_start_q;
  assign w_react_rise = i_react & ~r_react_q;

  // Fibonacci taps 8,6,5,4 mapped onto bit indices 7,5,4,3.
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_dly_load = DLY_W'(MIN_DELAY) + DLY_W'(r_lfsr[RAND_W-1:0]);

  always_comb begin
    w_state_next   = r_state;
    w_arm_cnt_next = r_arm_cnt;
    w_dly_next     = r_dly;
    w_rt_next      = r_rt;
    w_result_next  = r_result;
    w_best_next    = r_best;
    w_timeout_next = r_timeout;

    case (r_state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (w_start_rise) begin
          w_state_next   = S_ARM;
          w_arm_cnt_next = '0;
          w_timeout_next = 1'b0;
        end
      end
      S_ARM: begin
        if (w_react_rise) begin
          w_state_next = S_FAULT;
        end else if (r_arm_cnt == ARM_W'(ARM_TICKS - 1)) begin
          w_state_next = S_WAIT;
          w_dly_next   = w_dly_load;
        end else begin
          w_arm_cnt_next = r_arm_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (w_react_rise) begin
          w_state_next = S_FAULT;
        end else if (r_dly == DLY_W'(1)) begin
          w_state_next = S_GO;
          w_rt_next    = '0;
        end else begin
          w_dly_next = r_dly - 1'b1;
        end
      end
      S_GO: begin
        // A press in the final GO cycle still counts as a valid reaction.
        if (w_react_rise) begin
          w_state_next   = S_DONE;
          w_result_next  = r_rt;
          w_timeout_next = 1'b0;
          if (r_rt < r_best) begin
            w_best_next = r_rt;
          end
        end else if (r_rt == CNT_W'(TIMEOUT - 1)) begin
          w_state_next   = S_DONE;
          w_result_next  = CNT_W'(TIMEOUT);
          w_timeout_next = 1'b1;
        end else begin
          w_rt_next = r_rt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk5Hz) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_react_q <= 1'b0;
      r_lfsr    <= LFSR_SEED;
      r_arm_cnt <= '0;
      r_dly     <= '0;
      r_rt      <= '0;
      r_result  <= '0;
      r_best    <= '1;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= i_start;
      r_react_q <= i_react;
      r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
      r_arm_cnt <= w_arm_cnt_next;
      r_dly     <= w_dly_next;
      r_rt      <= w_rt_next;
      r_result  <= w_result_next;
      r_best    <= w_best_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign o_step_en      = (r_state == S_ARM);
  assign o_go_led       = (r_state == S_GO);
  assign o_false_start  = (r_state == S_FAULT);
  assign o_result_valid = (r_state == S_DONE);
  assign o_timeout      = r_timeout;
  assign o_result       = r_result;
  assign o_best         = r_best;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer: scripted and randomized rounds checked
// against a round-level model (phase lengths, result, running minimum best score).
module tb_reaction_sequencer;

  logic       clk5Hz = 1'b0;
  logic       reset_n;
  logic       start;
  logic       react;
  logic       step_en;
  logic       go_led;
  logic       false_start;
  logic       timeout;
  logic       result_valid;
  logic [7:0] result;
  logic [7:0] best;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: free-running LFSR image plus the round-level registers.
  logic [7:0] m_lfsr   = 8'hA5;
  logic [7:0] m_best   = 8'hFF;
  logic [7:0] m_result = 8'h00;

  reaction_sequencer dut (
    .clk5Hz         (clk5Hz),
    .reset_n        (reset_n),
    .i_start        (start),
    .i_react        (react),
    .o_step_en      (step_en),
    .o_go_led       (go_led),
    .o_false_start  (false_start),
    .o_timeout      (timeout),
    .o_result_valid (result_valid),
    .o_result       (result),
    .o_best         (best)
  );

  always #5 clk5Hz = ~clk5Hz;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic tick();
    @(posedge clk5Hz);
    if (!reset_n) m_lfsr = 8'hA5;
    else          m_lfsr = lfsr_step(m_lfsr);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walks the ARM phase; returns its length and the hold-off the DUT should load.
  task automatic walk_arm(output int n_arm, output int exp_dly);
    logic [7:0] pre;
    pre   = m_lfsr;
    n_arm = 0;
    while (step_en === 1'b1 && n_arm < 20) begin
      pre = m_lfsr;
      n_arm++;
      tick();
    end
    exp_dly = 5 + int'(pre[3:0]);
  endtask

  task automatic do_round(input bit do_start, input int rt_react, input bit poke_start);
    int n_arm, exp_dly, n_wait, n_go;
    if (do_start) pulse_start();
    n_tests++;
    if (step_en !== 1'b1 || result_valid !== 1'b0 || timeout !== 1'b0 || false_start !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_entry: step_en=%b valid=%b timeout=%b fs=%b, required 1 0 0 0",
               step_en, result_valid, timeout, false_start);
    end
    walk_arm(n_arm, exp_dly);
    n_tests++;
    if (n_arm !== 4) begin
      n_fail++;
      $display("FAIL arm_len: got %0d cycles, required 4", n_arm);
    end
    n_wait = 0;
    while (go_led !== 1'b1 && n_wait < 40) begin
      n_wait++;
      tick();
    end
    n_tests++;
    if (n_wait !== exp_dly) begin
      n_fail++;
      $display("FAIL wait_len: got %0d cycles, required %0d", n_wait, exp_dly);
    end
    if (rt_react >= 0) begin
      for (int i = 0; i < rt_react; i++) begin
        start = (poke_start && i == 0);
        tick();
      end
      start = 1'b0;
      react = 1'b1;
      tick();
      react = 1'b0;
      m_result = 8'(rt_react);
      if (m_result < m_best) m_best = m_result;
    end else begin
      n_go = 0;
      while (go_led === 1'b1 && n_go < 100) begin
        n_go++;
        tick();
      end
      n_tests++;
      if (n_go !== 50) begin
        n_fail++;
        $display("FAIL go_len: got %0d cycles, required 50", n_go);
      end
      m_result = 8'd50;
    end
    n_tests++;
    if (result_valid !== 1'b1 || go_led !== 1'b0 || step_en !== 1'b0 ||
        timeout !== (rt_react < 0) || result !== m_result || best !== m_best) begin
      n_fail++;
      $display("FAIL round_done: valid=%b go=%b step=%b timeout=%b result=%0d best=%0d, required 1 0 0 %b %0d %0d",
               result_valid, go_led, step_en, timeout, result, best, (rt_react < 0), m_result, m_best);
    end
    $display("[TB] round rt=%0d wait=%0d result=%0d best=%0d timeout=%b",
             rt_react, exp_dly, result, best, timeout);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    react   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (step_en !== 1'b0 || go_led !== 1'b0 || false_start !== 1'b0 || result_valid !== 1'b0 ||
        timeout !== 1'b0 || result !== 8'h00 || best !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset: step=%b go=%b fs=%b valid=%b timeout=%b result=%0h best=%0h, required 0 0 0 0 0 00 ff",
               step_en, go_led, false_start, result_valid, timeout, result, best);
    end
    $display("[TB] reset released");
  endtask

  // wait_idx: 0 = react in ARM cycle 2, k>0 = WAIT cycle k, -1 = last WAIT cycle.
  task automatic test_false_start(input int wait_idx);
    int n_arm, exp_dly, idx;
    pulse_start();
    if (wait_idx == 0) begin
      tick();
    end else begin
      walk_arm(n_arm, exp_dly);
      idx = (wait_idx < 0) ? exp_dly : wait_idx;
      repeat (idx - 1) tick();
    end
    react = 1'b1;
    tick();
    react = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (false_start !== 1'b1 || go_led !== 1'b0 || result_valid !== 1'b0 ||
          result !== m_result || best !== m_best) begin
        n_fail++;
        $display("FAIL false_start[%0d]: fs=%b go=%b valid=%b result=%0d best=%0d, required 1 0 0 %0d %0d",
                 i, false_start, go_led, result_valid, result, m_best, m_result, m_best);
      end
      tick();
    end
    $display("[TB] false start idx=%0d fs=%b best=%0d", wait_idx, false_start, best);
    do_round(1'b1, 5, 1'b0);
  endtask

  task automatic test_timeout();
    react = 1'b1;
    tick();
    tick();
    do_round(1'b1, -1, 1'b0);
    react = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int rt, gap;
    for (int r = 0; r < 6; r++) begin
      rt  = int'($urandom_range(2, 40));
      gap = int'($urandom_range(0, 3));
      repeat (gap) tick();
      n_tests++;
      if (result_valid !== 1'b1 || result !== m_result) begin
        n_fail++;
        $display("FAIL done_hold: valid=%b result=%0d, required 1 %0d", result_valid, result, m_result);
      end
      do_round(1'b1, rt, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_reset_mid_go();
    int n_arm, exp_dly, guard;
    pulse_start();
    walk_arm(n_arm, exp_dly);
    guard = 0;
    while (go_led !== 1'b1 && guard < 40) begin
      guard++;
      tick();
    end
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_best   = 8'hFF;
    m_result = 8'h00;
    n_tests++;
    if (go_led !== 1'b0 || step_en !== 1'b0 || best !== 8'hFF || result_valid !== 1'b0 ||
        result !== 8'h00 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_go: go=%b step=%b best=%0h valid=%b result=%0h timeout=%b, required 0 0 ff 0 00 0",
               go_led, step_en, best, result_valid, result, timeout);
    end
    $display("[TB] reset during GO, best=%0h", best);
    do_round(1'b1, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    do_round(1'b1, 3, 1'b0);
    do_round(1'b1, 7, 1'b0);
    do_round(1'b1, 1, 1'b0);
    test_false_start(2);
    test_false_start(-1);
    test_false_start(0);
    test_timeout();
    do_round(1'b1, 49, 1'b0);
    test_random();
    do_round(1'b1, 0, 1'b0);
    test_reset_mid_go();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
